// File: rtl/pid_seq_ctrl.sv
// rtl/pid_seq_ctrl.sv - sampled PID loop, one shared 8x16 multiplier, six-state sequencer
// Define PID_DERIV_EN to include the derivative term (MD state); default build is PI only.
module pid_seq_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int FRAC       = 4
) (
    input  logic                  clk,
    input  logic                  RSTn,
    input  logic                  enable,
    input  logic [15:0]           period,
    input  logic [DATA_WIDTH-1:0] setpoint,
    input  logic signed [7:0]     kp,
    input  logic signed [7:0]     ki,
    input  logic signed [7:0]     kd,
    input  logic                  clr_integ,
    input  logic [DATA_WIDTH-1:0] data_adc,
    output logic [DATA_WIDTH-1:0] data_dac,
    output logic                  dac_valid,
    output logic                  busy,
    output logic                  overrun
);
    localparam int EW = DATA_WIDTH + 1;
    localparam int AW = 26;
    localparam logic [AW-1:0] DAC_MAX = {{(AW-DATA_WIDTH){1'b0}}, {DATA_WIDTH{1'b1}}};

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CAP  = 3'd1,
        MP   = 3'd2,
        MI   = 3'd3,
`ifdef PID_DERIV_EN
        MD   = 3'd4,
`endif
        OUT  = 3'd5
    } state_t;

    state_t state, state_nx;

    logic [15:0]          cnt;
    logic                 tick;
    logic signed [EW-1:0] e_new, e_q;
    logic signed [16:0]   integ_sum;
    logic signed [15:0]   integ, integ_sat;
    logic signed [7:0]    mul_a;
    logic signed [15:0]   mul_b;
    logic signed [23:0]   product;
    logic signed [AW-1:0] acc, shifted;
    logic [DATA_WIDTH-1:0] dac_next;

    assign tick = enable && (cnt == 16'd0);
    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn)
            cnt <= 16'd0;
        else if (!enable || tick)
            cnt <= period;
        else
            cnt <= cnt - 16'd1;
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (tick) state_nx = CAP;
            CAP:  state_nx = MP;
            MP:   state_nx = MI;
`ifdef PID_DERIV_EN
            MI:   state_nx = MD;
            MD:   state_nx = OUT;
`else
            MI:   state_nx = OUT;
`endif
            OUT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Ticks that land while a computation is in flight are lost; remember that.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn)
            overrun <= 1'b0;
        else if (!enable)
            overrun <= 1'b0;
        else if (tick && busy)
            overrun <= 1'b1;
    end

    assign e_new     = $signed({1'b0, setpoint}) - $signed({1'b0, data_adc});
    assign integ_sum = {integ[15], integ} + 17'(e_new);
    assign integ_sat = (integ_sum[16] != integ_sum[15]) ?
                       (integ_sum[16] ? 16'sh8000 : 16'sh7FFF) : integ_sum[15:0];

`ifdef PID_DERIV_EN
    logic signed [EW-1:0] e_prev;
    logic signed [EW:0]   d_new, d_q;

    assign d_new = {e_new[EW-1], e_new} - {e_prev[EW-1], e_prev};

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            e_prev <= '0;
            d_q    <= '0;
        end else begin
            if (clr_integ)
                e_prev <= '0;
            else if (state == CAP)
                e_prev <= e_new;
            if (state == CAP)
                d_q <= d_new;
        end
    end
`else
    logic unused_kd;
    assign unused_kd = ^kd;
`endif

    // Clear has priority over the CAP update so a coincident clear leaves integ at zero.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            integ <= '0;
            e_q   <= '0;
        end else begin
            if (clr_integ)
                integ <= '0;
            else if (state == CAP)
                integ <= integ_sat;
            if (state == CAP)
                e_q <= e_new;
        end
    end

    always_comb begin
        mul_a = kp;
        mul_b = 16'(e_q);
        case (state)
            MI: begin
                mul_a = ki;
                mul_b = integ;
            end
`ifdef PID_DERIV_EN
            MD: begin
                mul_a = kd;
                mul_b = 16'(d_q);
            end
`endif
            default: ;
        endcase
    end

    assign product = mul_a * mul_b;

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn)
            acc <= '0;
        else if (state == CAP)
            acc <= '0;
        else if (state != IDLE && state != OUT)
            acc <= acc + AW'(product);
    end

    assign shifted = acc >>> FRAC;

    always_comb begin
        dac_next = shifted[DATA_WIDTH-1:0];
        if (shifted[AW-1])
            dac_next = '0;
        else if ($unsigned(shifted) > DAC_MAX)
            dac_next = DAC_MAX[DATA_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            data_dac  <= '0;
            dac_valid <= 1'b0;
        end else begin
            dac_valid <= (state == OUT);
            if (state == OUT)
                data_dac <= dac_next;
        end
    end
endmodule
